// File: rtl/car_pkg.sv
// Shared state encoding and constants for the car motion controller.
package car_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MOVE_L  = 3'd1;
  localparam logic [2:0] ST_MOVE_R  = 3'd2;
  localparam logic [2:0] ST_COLLIDE = 3'd3;
  localparam logic [2:0] ST_RESTART = 3'd4;

  localparam int unsigned SPEED_W = 4;

  typedef enum logic [2:0] {
    StIdle    = ST_IDLE,
    StMoveL   = ST_MOVE_L,
    StMoveR   = ST_MOVE_R,
    StCollide = ST_COLLIDE,
    StRestart = ST_RESTART
  } car_state_t;

  // Idle and both move states share the same button decode: one button only selects a direction.
  function automatic car_state_t btn_dir(input logic l, input logic r);
    if (l && !r) begin
      return StMoveL;
    end else if (r && !l) begin
      return StMoveR;
    end
    return StIdle;
  endfunction

endpackage

// File: rtl/car_motion_ctrl_if.sv
// Button/frame inputs and car status outputs of the motion controller.
interface car_motion_ctrl_if #(
  parameter int unsigned X_WIDTH = 10
);
  import car_pkg::*;

  logic               btnc_raw;
  logic               btnr_raw;
  logic               btnl_raw;
  logic               frame_tick;
  logic [X_WIDTH-1:0] car_x;
  logic [2:0]         current_state;
  logic               move_left;
  logic               move_right;
  logic               reset_car_pos;
  logic               stop;
  logic [SPEED_W-1:0] speed;

  modport master (
    output btnc_raw, btnr_raw, btnl_raw, frame_tick,
    input  car_x, current_state, move_left, move_right, reset_car_pos, stop, speed
  );

  modport slave (
    input  btnc_raw, btnr_raw, btnl_raw, frame_tick,
    output car_x, current_state, move_left, move_right, reset_car_pos, stop, speed
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one mechanical button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    // Any cycle where input agrees with output restarts the stability count.
    if (sync_q[1] != db_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/car_motion_ctrl.sv
// Car FSM and X datapath for the sprite display; define CAR_ACCEL_EN to enable the
// per-frame speed ramp (otherwise speed is fixed at STEP).
module car_motion_ctrl
  import car_pkg::*;
#(
  parameter int unsigned X_WIDTH         = 10,
  parameter int unsigned X_MIN           = 200,
  parameter int unsigned X_MAX           = 400,
  parameter int unsigned X_RESET         = 300,
  parameter int unsigned STEP            = 2,
  parameter int unsigned STEP_MAX        = 8,
  parameter int unsigned ACCEL_FRAMES    = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic              clk,
  input logic              rst,
  car_motion_ctrl_if.slave bus
);

  localparam logic [X_WIDTH:0]   XMinW  = (X_WIDTH + 1)'(X_MIN);
  localparam logic [X_WIDTH:0]   XMaxW  = (X_WIDTH + 1)'(X_MAX);
  localparam logic [SPEED_W-1:0] StepW  = SPEED_W'(STEP);

  if (STEP == 0 || STEP > STEP_MAX || ACCEL_FRAMES == 0 || X_MIN > X_MAX) begin : g_cfg_err
    $error("car_motion_ctrl: inconsistent position/speed parameters");
  end

  logic btnc_db, btnr_db, btnl_db;
  logic btnc_prev_q;
  logic btnc_edge;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
    .clk (clk),
    .rst (rst),
    .raw (bus.btnc_raw),
    .db  (btnc_db)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk (clk),
    .rst (rst),
    .raw (bus.btnr_raw),
    .db  (btnr_db)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk (clk),
    .rst (rst),
    .raw (bus.btnl_raw),
    .db  (btnl_db)
  );

  assign btnc_edge = btnc_db & ~btnc_prev_q;

  car_state_t         state_q, state_d;
  logic [X_WIDTH-1:0] car_x_q, car_x_d;
  logic [X_WIDTH:0]   nx_l, nx_r;
  logic [SPEED_W-1:0] speed_cur;

  // One extra bit so a left step below zero shows up as a set MSB instead of wrapping.
  assign nx_l = {1'b0, car_x_q} - (X_WIDTH + 1)'(speed_cur);
  assign nx_r = {1'b0, car_x_q} + (X_WIDTH + 1)'(speed_cur);

  always_comb begin
    state_d = state_q;
    car_x_d = car_x_q;
    if (btnc_edge) begin
      state_d = StRestart;
      car_x_d = X_WIDTH'(X_RESET);
    end else begin
      unique case (state_q)
        StIdle: state_d = btn_dir(btnl_db, btnr_db);
        StMoveL: begin
          state_d = btn_dir(btnl_db, btnr_db);
          if (bus.frame_tick) begin
            if (nx_l[X_WIDTH] || nx_l < XMinW) begin
              car_x_d = X_WIDTH'(X_MIN);
              state_d = StCollide;
            end else begin
              car_x_d = nx_l[X_WIDTH-1:0];
            end
          end
        end
        StMoveR: begin
          state_d = btn_dir(btnl_db, btnr_db);
          if (bus.frame_tick) begin
            if (nx_r > XMaxW) begin
              car_x_d = X_WIDTH'(X_MAX);
              state_d = StCollide;
            end else begin
              car_x_d = nx_r[X_WIDTH-1:0];
            end
          end
        end
        StCollide: state_d = StCollide;
        StRestart: begin
          state_d = StIdle;
          car_x_d = X_WIDTH'(X_RESET);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      car_x_q     <= X_WIDTH'(X_RESET);
      btnc_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      car_x_q     <= car_x_d;
      btnc_prev_q <= btnc_db;
    end
  end

`ifdef CAR_ACCEL_EN
  localparam int unsigned FcW = $clog2(ACCEL_FRAMES + 1);

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [FcW-1:0]     frame_cnt_q, frame_cnt_d;

  // Ramp only while staying in the same move state; any other transition restarts at STEP.
  always_comb begin
    speed_d     = speed_q;
    frame_cnt_d = frame_cnt_q;
    if (state_d == state_q && (state_q == StMoveL || state_q == StMoveR)) begin
      if (bus.frame_tick) begin
        if (frame_cnt_q == FcW'(ACCEL_FRAMES - 1)) begin
          frame_cnt_d = '0;
          if (speed_q < SPEED_W'(STEP_MAX)) begin
            speed_d = speed_q + 1'b1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end else begin
      speed_d     = StepW;
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q     <= StepW;
      frame_cnt_q <= '0;
    end else begin
      speed_q     <= speed_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign speed_cur = speed_q;
`else
  assign speed_cur = StepW;
`endif

  assign bus.car_x         = car_x_q;
  assign bus.current_state = state_q;
  assign bus.move_left     = (state_q == StMoveL);
  assign bus.move_right    = (state_q == StMoveR);
  assign bus.stop          = (state_q == StCollide);
  assign bus.reset_car_pos = (state_q == StRestart);
  assign bus.speed         = speed_cur;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl with short debounce and a 20-cycle frame period.
module tb_car_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  car_motion_ctrl_if #(.X_WIDTH(10)) bus ();

  car_motion_ctrl #(
    .X_WIDTH         (10),
    .X_MIN           (200),
    .X_MAX           (400),
    .X_RESET         (300),
    .STEP            (2),
    .STEP_MAX        (8),
    .ACCEL_FRAMES    (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each frame: 19 quiet cycles then a one-cycle tick; returns on the negedge after the tick.
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      repeat (19) @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic press_btnc(output int pulses, output int x_at_pulse);
    pulses     = 0;
    x_at_pulse = -1;
    bus.btnc_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.reset_car_pos) begin
        pulses++;
        x_at_pulse = int'(bus.car_x);
      end
    end
    bus.btnc_raw = 1'b0;
    wait_cycles(8);
  endtask

  int p, xr;
`ifdef CAR_ACCEL_EN
  int spd, nfr, xm;
`endif

  initial begin
    bus.btnc_raw   = 1'b0;
    bus.btnr_raw   = 1'b0;
    bus.btnl_raw   = 1'b0;
    bus.frame_tick = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);
    check("rst_car_x", bus.car_x, 300);
    check("rst_state", bus.current_state, 0);
    check("rst_stop", bus.stop, 0);
    check("rst_speed", bus.speed, 2);
    check("rst_flags", {bus.move_left, bus.move_right, bus.reset_car_pos}, 0);

    // Both buttons held: no motion.
    bus.btnl_raw = 1'b1;
    bus.btnr_raw = 1'b1;
    wait_cycles(10);
    run_frames(5);
    check("both_state", bus.current_state, 0);
    check("both_car_x", bus.car_x, 300);
    bus.btnl_raw = 1'b0;
    bus.btnr_raw = 1'b0;
    wait_cycles(10);

    // Three-cycle glitch is rejected.
    bus.btnr_raw = 1'b1;
    wait_cycles(3);
    bus.btnr_raw = 1'b0;
    wait_cycles(10);
    check("glitch_state", bus.current_state, 0);

    bus.btnr_raw = 1'b1;
    wait_cycles(10);
    check("mover_state", bus.current_state, 2);
    check("mover_flag", bus.move_right, 1);
    run_frames(1);
    check("mover_car_x", bus.car_x, 302);
    bus.btnr_raw = 1'b0;
    wait_cycles(10);
    check("release_state", bus.current_state, 0);
    check("release_car_x", bus.car_x, 302);

    press_btnc(p, xr);
    check("restart_idle_pulses", p, 1);
    check("restart_idle_x", xr, 300);
    check("restart_idle_state", bus.current_state, 0);

`ifndef CAR_ACCEL_EN
    // 50 ticks of 2 px from 300 land exactly on 200; tick 51 collides.
    bus.btnl_raw = 1'b1;
    wait_cycles(10);
    check("movel_state", bus.current_state, 1);
    run_frames(50);
    check("edge_car_x", bus.car_x, 200);
    check("edge_state", bus.current_state, 1);
    check("edge_stop", bus.stop, 0);
    run_frames(1);
    check("coll_car_x", bus.car_x, 200);
    check("coll_state", bus.current_state, 3);
    check("coll_stop", bus.stop, 1);
    run_frames(9);
    check("coll_hold_x", bus.car_x, 200);
    check("coll_speed", bus.speed, 2);
    bus.btnl_raw = 1'b0;
    wait_cycles(10);
    check("coll_release_state", bus.current_state, 3);
    bus.btnr_raw = 1'b1;
    wait_cycles(10);
    run_frames(1);
    check("coll_ignore_r_state", bus.current_state, 3);
    check("coll_ignore_r_x", bus.car_x, 200);
    bus.btnr_raw = 1'b0;
    wait_cycles(10);
`else
    // Speed ramps every 2 ticks up to 8; 300 + 2+2+3+3+...+8 reaches 394 after 17 ticks.
    bus.btnr_raw = 1'b1;
    wait_cycles(10);
    spd = 2;
    nfr = 0;
    xm  = 300;
    for (int k = 1; k <= 17; k++) begin
      run_frames(1);
      xm += spd;
      nfr++;
      if (nfr == 2) begin
        nfr = 0;
        if (spd < 8) spd++;
      end
      check($sformatf("accel_x_%0d", k), bus.car_x, xm);
      check($sformatf("accel_speed_%0d", k), bus.speed, spd);
    end
    run_frames(1);
    check("accel_coll_x", bus.car_x, 400);
    check("accel_coll_state", bus.current_state, 3);
    check("accel_coll_speed", bus.speed, 2);
    bus.btnr_raw = 1'b0;
    wait_cycles(10);
`endif

    press_btnc(p, xr);
    check("restart_coll_pulses", p, 1);
    check("restart_coll_x", xr, 300);
    check("restart_coll_state", bus.current_state, 0);
    check("restart_coll_car_x", bus.car_x, 300);

    // Asynchronous reset in the middle of motion.
    bus.btnr_raw = 1'b1;
    wait_cycles(10);
    run_frames(2);
    check("pre_rst_car_x", bus.car_x, 304);
    #2 rst = 1'b1;
    #1;
    check("async_rst_car_x", bus.car_x, 300);
    check("async_rst_state", bus.current_state, 0);
    bus.btnr_raw = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(10);
    check("post_rst_state", bus.current_state, 0);
    check("post_rst_car_x", bus.car_x, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
